// File: rtl/serial_eq_pkg.sv
// Shared types and constants for the serial word equality checker.
// FSM state encoding and the default word width.
package serial_eq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_eq_checker_amisha_eq1.sv
// One-bit equality cell: eq_amisha is high when both inputs carry the same level.
module eq1_Amisha (
    input  logic i0_amisha,
    input  logic i1_amisha,
    output logic eq_amisha
);

    // Sum-of-products form: both low or both high.
    assign eq_amisha = (~i0_amisha & ~i1_amisha) | (i0_amisha & i1_amisha);

endmodule

// File: rtl/serial_eq_checker_amisha.sv
// Serial word comparator folding eq1_Amisha results over WIDTH accepted bit pairs.
// Define SERIAL_EQ_MISMATCH_CNT_EN to build the mismatch counter and first-index logic.
module serial_eq_checker_amisha
    import serial_eq_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    input  logic             start_amisha,
    input  logic             bit_valid_amisha,
    input  logic             a_bit_amisha,
    input  logic             b_bit_amisha,
    output logic             busy_amisha,
    output logic             done_amisha,
    output logic             eq_amisha,
    output logic [CNT_W-1:0] mismatch_cnt_amisha,
    output logic [CNT_W-1:0] first_idx_amisha
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic             eq_acc;
    logic             bit_eq;
    logic             start_ok;
    logic             accept;
    logic             last_bit;

    eq1_Amisha u_eq1 (
        .i0_amisha (a_bit_amisha),
        .i1_amisha (b_bit_amisha),
        .eq_amisha (bit_eq)
    );

    // A start is honoured only in IDLE or in the DONE cycle; in RUN it is ignored.
    assign start_ok = start_amisha && ((state == IDLE) || (state == DONE));
    assign accept   = (state == RUN) && bit_valid_amisha;
    assign last_bit = accept && (bit_cnt == CNT_W'(WIDTH - 1));

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_amisha) next_state = RUN;
            RUN:     if (last_bit)     next_state = DONE;
            DONE:    next_state = start_amisha ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are flops loaded from the next state, so they track the FSM with no input-to-output path.
    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            busy_amisha <= 1'b0;
            done_amisha <= 1'b0;
            bit_cnt     <= '0;
            eq_acc      <= 1'b0;
            eq_amisha   <= 1'b0;
        end else begin
            busy_amisha <= (next_state == RUN);
            done_amisha <= (next_state == DONE);
            if (start_ok) begin
                bit_cnt   <= '0;
                eq_acc    <= 1'b1;
                eq_amisha <= 1'b0;
            end else if (accept) begin
                bit_cnt <= bit_cnt + 1'b1;
                eq_acc  <= eq_acc & bit_eq;
                if (last_bit) begin
                    eq_amisha <= eq_acc & bit_eq;
                end
            end
        end
    end

`ifdef SERIAL_EQ_MISMATCH_CNT_EN
    logic [CNT_W-1:0] mism_acc;
    logic [CNT_W-1:0] idx_acc;
    logic             first_seen;
    logic             mismatch;
    logic [CNT_W-1:0] mism_next;
    logic [CNT_W-1:0] idx_next;

    assign mismatch  = ~bit_eq;
    assign mism_next = mism_acc + {{(CNT_W-1){1'b0}}, mismatch};
    assign idx_next  = (mismatch && !first_seen) ? bit_cnt : idx_acc;

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            mism_acc            <= '0;
            idx_acc             <= '0;
            first_seen          <= 1'b0;
            mismatch_cnt_amisha <= '0;
            first_idx_amisha    <= '0;
        end else begin
            if (start_ok) begin
                mism_acc            <= '0;
                idx_acc             <= '0;
                first_seen          <= 1'b0;
                mismatch_cnt_amisha <= '0;
                first_idx_amisha    <= '0;
            end else if (accept) begin
                mism_acc   <= mism_next;
                idx_acc    <= idx_next;
                first_seen <= first_seen | mismatch;
                if (last_bit) begin
                    mismatch_cnt_amisha <= mism_next;
                    first_idx_amisha    <= idx_next;
                end
            end
        end
    end
`else
    assign mismatch_cnt_amisha = '0;
    assign first_idx_amisha    = '0;
`endif

endmodule

// File: tb/tb_serial_eq_checker_amisha.sv
// Directed bench for serial_eq_checker_amisha with a result scoreboard.
// Expected count/index follow SERIAL_EQ_MISMATCH_CNT_EN the same way the design does.
module tb_serial_eq_checker_amisha;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    typedef struct {
        logic          eq;
        logic [CW-1:0] cnt;
        logic [CW-1:0] idx;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          bit_valid;
    logic          a_bit;
    logic          b_bit;
    logic          busy;
    logic          done;
    logic          eq;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    serial_eq_checker_amisha #(.WIDTH(W)) dut (
        .clk_amisha          (clk),
        .rst_n_amisha        (rst_n),
        .start_amisha        (start),
        .bit_valid_amisha    (bit_valid),
        .a_bit_amisha        (a_bit),
        .b_bit_amisha        (b_bit),
        .busy_amisha         (busy),
        .done_amisha         (done),
        .eq_amisha           (eq),
        .mismatch_cnt_amisha (cnt),
        .first_idx_amisha    (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t          e;
        logic [W-1:0]  d;
        d     = a ^ b;
        e.eq  = (d == '0);
        e.cnt = '0;
        e.idx = '0;
`ifdef SERIAL_EQ_MISMATCH_CNT_EN
        e.cnt = CW'($countones(d));
        for (int i = W - 1; i >= 0; i--) begin
            if (d[i]) e.idx = CW'(i);
        end
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_eq"},   eq,   0);
        check({tag, "_cnt"},  cnt,  0);
        check({tag, "_idx"},  idx,  0);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_eq"},  eq,  e.eq);
            check({tag, "_cnt"}, cnt, e.cnt);
            check({tag, "_idx"}, idx, e.idx);
        end
    endtask

    // Streams one word LSB first; returns during the DONE cycle.
    task automatic send_word(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit gaps, input bit valid_on_start, input bit start_in_run);
        start     = 1'b1;
        bit_valid = valid_on_start;
        a_bit     = 1'b1;
        b_bit     = 1'b0;
        tick();
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_no_done_start"}, done, 0);
        sb.push_back(model(a, b));
        for (int i = 0; i < W; i++) begin
            if (gaps) begin
                start     = start_in_run;
                bit_valid = 1'b0;
                a_bit     = 1'b1;
                b_bit     = 1'b0;
                tick();
                check({tag, "_gap_busy"}, busy, 1);
                check({tag, "_gap_done"}, done, 0);
            end
            start     = start_in_run && (i % 2 == 1);
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            tick();
            if (i < W - 1) begin
                check({tag, "_early_done"}, done, 0);
            end else begin
                check({tag, "_done"}, done, 1);
                check({tag, "_busy_fall"}, busy, 0);
                compare_result(tag);
            end
        end
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            start     = 1'b0;
            bit_valid = 1'($urandom);
            a_bit     = 1'($urandom);
            b_bit     = 1'($urandom);
            tick();
            check({tag, "_idle_done"}, done, 0);
            check({tag, "_idle_busy"}, busy, 0);
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;

        // Reset held while inputs toggle randomly.
        for (int i = 0; i < 3; i++) begin
            start     = 1'($urandom);
            bit_valid = 1'($urandom);
            a_bit     = 1'($urandom);
            b_bit     = 1'($urandom);
            tick();
            check_zero("reset");
        end
        start = 1'b0;
        #2 rst_n = 1'b1;
        idle("post_reset", 3);

        send_word("a5_a5", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle("a5_a5", 1);
        check("a5_a5_eq_held", eq, 1);

        send_word("a5_25", 8'hA5, 8'h25, 1'b0, 1'b0, 1'b0);
        idle("a5_25", 1);
        send_word("00_ff", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        idle("00_ff", 1);

        send_word("3c_nogap", 8'h3C, 8'h34, 1'b0, 1'b0, 1'b0);
        idle("3c_nogap", 1);
        send_word("3c_gap", 8'h3C, 8'h34, 1'b1, 1'b0, 1'b0);
        idle("3c_gap", 1);

        // Abort after three bits: reset must clear everything at once.
        start     = 1'b1;
        bit_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            a_bit     = 1'b1;
            b_bit     = 1'b0;
            tick();
        end
        check("abort_busy_before", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check_zero("abort");
        #2 rst_n = 1'b1;
        bit_valid = 1'b0;
        idle("abort", 2);
        send_word("0f_0f", 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0);
        idle("0f_0f", 1);

        // Start with valid high (bit ignored) and start pulses during RUN, then back-to-back words.
        send_word("start_valid", 8'h5A, 8'h5B, 1'b0, 1'b1, 1'b1);
        send_word("b2b_c3", 8'hC3, 8'hC3, 1'b0, 1'b0, 1'b0);
        send_word("b2b_f0", 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b1);
        idle("final", 2);

        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
